// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, counter
// widths and a helper for sizing the parametrised counters.
package reset_seq_pkg;

  // Encoding is visible on seq_state for debug.
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } seq_state_e;

  localparam int SEQ_STATE_W     = 2;
  localparam int LOCK_LOSS_CNT_W = 8;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and its environment.
//   pll_lock      raw PLL lock, asynchronous to clk
//   sw_reset      synchronous active-high soft reset request
//   stage_resetn  per-stage active-low resets, bit 0 released first
//   all_released  high once every stage is released
//   seq_state     current sequencer state (debug)
//   lock_loss_cnt saturating count of lock-loss events
// master: the sequencer. slave: the logic supplying lock/soft reset and
// consuming the resets.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  import reset_seq_pkg::*;

  logic                       pll_lock;
  logic                       sw_reset;
  logic [NUM_STAGES-1:0]      stage_resetn;
  logic                       all_released;
  logic [SEQ_STATE_W-1:0]     seq_state;
  logic [LOCK_LOSS_CNT_W-1:0] lock_loss_cnt;

  modport master (
    input  pll_lock, sw_reset,
    output stage_resetn, all_released, seq_state, lock_loss_cnt
  );

  modport slave (
    output pll_lock, sw_reset,
    input  stage_resetn, all_released, seq_state, lock_loss_cnt
  );

endinterface

// File: rtl/reset_sequencer_sync_ff.sv
// Multi-flop synchroniser for slow asynchronous control bits.
//   clk    destination clock
//   rst_n  asynchronous active-low clear of every stage
//   d_i    asynchronous input bits
//   q_o    synchronised output, STAGES clocks of latency
module sync_ff #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: qualifies PLL lock, holds all resets for a fixed count,
// then releases NUM_STAGES active-low resets in order, STAGE_GAP apart.
// Lock loss or a soft reset request pulls every stage back into reset.
//   clk        sequencer clock (pixel domain)
//   ext_reset  asynchronous active-low reset of the whole block
//   bus        reset_sequencer_if master: pll_lock/sw_reset in, resets,
//              all_released, seq_state and lock_loss_cnt out
//
// state   | meaning
// HOLD    | waiting for LOCK_FILTER consecutive synchronised lock cycles
// COUNT   | lock qualified, all stages held for HOLD_CYCLES
// RELEASE | stages releasing one by one every STAGE_GAP cycles
// RUN     | every stage released
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 16
) (
  input  logic               clk,
  input  logic               ext_reset,
  reset_sequencer_if.master  bus
);

  localparam int FILT_W = cnt_w(LOCK_FILTER);
  localparam int HOLD_W = cnt_w(HOLD_CYCLES);
  localparam int GAP_W  = cnt_w(STAGE_GAP);

  // Counters compare against "target - 1" so the transition lands on the
  // edge where the count would reach the target.
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

  logic                       lock_s;
  seq_state_e                 state_q;
  logic [FILT_W-1:0]          filt_q;
  logic [HOLD_W-1:0]          hold_q;
  logic [GAP_W-1:0]           gap_q;
  logic [NUM_STAGES-1:0]      stage_q;
  logic [NUM_STAGES-1:0]      stage_d;
  logic                       all_rel_q;
  logic [LOCK_LOSS_CNT_W-1:0] loss_q;

  sync_ff #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (ext_reset),
    .d_i   (bus.pll_lock),
    .q_o   (lock_s)
  );

  // Released stages form a thermometer code; the next release shifts in a 1.
  assign stage_d = (stage_q << 1) | NUM_STAGES'(1);

  always_ff @(posedge clk or negedge ext_reset) begin
    if (!ext_reset) begin
      state_q   <= ST_HOLD;
      filt_q    <= '0;
      hold_q    <= '0;
      gap_q     <= '0;
      stage_q   <= '0;
      all_rel_q <= 1'b0;
      loss_q    <= '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (!lock_s) begin
            filt_q <= '0;
          end else if (filt_q == FILT_LAST) begin
            filt_q  <= '0;
            hold_q  <= '0;
            state_q <= ST_COUNT;
          end else begin
            filt_q <= filt_q + 1'b1;
          end
        end
        default: begin
          // Lock loss outranks a simultaneous soft reset.
          if (!lock_s) begin
            state_q   <= ST_HOLD;
            filt_q    <= '0;
            stage_q   <= '0;
            all_rel_q <= 1'b0;
            if (loss_q != '1) loss_q <= loss_q + 1'b1;
          end else if (bus.sw_reset) begin
            // Lock is still good, so skip re-qualification.
            state_q   <= ST_COUNT;
            hold_q    <= '0;
            stage_q   <= '0;
            all_rel_q <= 1'b0;
          end else begin
            case (state_q)
              ST_COUNT: begin
                if (hold_q == HOLD_LAST) begin
                  stage_q <= stage_d;
                  gap_q   <= '0;
                  if (&stage_d) begin
                    state_q   <= ST_RUN;
                    all_rel_q <= 1'b1;
                  end else begin
                    state_q <= ST_RELEASE;
                  end
                end else begin
                  hold_q <= hold_q + 1'b1;
                end
              end
              ST_RELEASE: begin
                if (gap_q == GAP_LAST) begin
                  gap_q   <= '0;
                  stage_q <= stage_d;
                  if (&stage_d) begin
                    state_q   <= ST_RUN;
                    all_rel_q <= 1'b1;
                  end
                end else begin
                  gap_q <= gap_q + 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.stage_resetn  = stage_q;
  assign bus.all_released  = all_rel_q;
  assign bus.seq_state     = state_q;
  assign bus.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int N    = 3;
  localparam int SYNC = 2;
  localparam int LF   = 8;
  localparam int HC   = 16;
  localparam int GAP  = 16;

  logic clk = 1'b0;
  logic ext_reset = 1'b0;
  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_STAGES(N)) bus ();

  reset_sequencer #(
    .NUM_STAGES  (N),
    .SYNC_STAGES (SYNC),
    .LOCK_FILTER (LF),
    .HOLD_CYCLES (HC),
    .STAGE_GAP   (GAP)
  ) dut (
    .clk       (clk),
    .ext_reset (ext_reset),
    .bus       (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: timestamps rather than counters.
  int m_edge, m_run, m_start, m_loss;
  bit m_seq;
  bit m_lq[$];

  task automatic model_reset();
    m_edge = 0; m_run = 0; m_start = 0; m_loss = 0; m_seq = 0;
    m_lq.delete();
    for (int i = 0; i < SYNC; i++) m_lq.push_back(1'b0);
  endtask

  task automatic model_step(input bit pll, input bit sw);
    bit ls;
    m_edge++;
    ls = m_lq.pop_front();
    m_lq.push_back(pll);
    if (m_seq) begin
      if (!ls) begin
        m_seq = 0; m_run = 0;
        if (m_loss < 255) m_loss++;
      end else if (sw) begin
        m_start = m_edge;
      end
    end else begin
      m_run = ls ? m_run + 1 : 0;
      if (m_run == LF) begin
        m_seq = 1; m_start = m_edge;
      end
    end
  endtask

  function automatic int m_n();
    int n;
    if (!m_seq || m_edge < m_start + HC) return 0;
    n = (m_edge - m_start - HC) / GAP + 1;
    return (n > N) ? N : n;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, m_edge);
    end
  endtask

  task automatic check_model(input string name);
    int n, es, est, ea;
    n   = m_n();
    es  = (1 << n) - 1;
    est = !m_seq ? 0 : (n == 0) ? 1 : (n < N) ? 2 : 3;
    ea  = (n == N) ? 1 : 0;
    tests++;
    if (int'(bus.stage_resetn) != es || int'(bus.seq_state) != est ||
        int'(bus.all_released) != ea || int'(bus.lock_loss_cnt) != m_loss) begin
      fails++;
      $display("FAIL %s edge %0d: got stage=%b state=%0d all=%0d cnt=%0d expected stage=%b state=%0d all=%0d cnt=%0d",
               name, m_edge, bus.stage_resetn, bus.seq_state, bus.all_released, bus.lock_loss_cnt,
               es[N-1:0], est, ea, m_loss);
    end
  endtask

  // Called at a negedge: drive, clock, then check at the following negedge.
  task automatic step(input bit pll, input bit sw, input string name);
    bus.pll_lock = pll;
    bus.sw_reset = sw;
    @(posedge clk);
    model_step(pll, sw);
    @(negedge clk);
    check_model(name);
  endtask

  task automatic do_reset();
    ext_reset    = 1'b0;
    bus.pll_lock = 1'b0;
    bus.sw_reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check_model("reset_state");
    ext_reset = 1'b1;
  endtask

  typedef struct {
    bit         pll;
    bit         sw;
    int         cycles;
    logic [2:0] stage;
    logic [1:0] state;
    bit         all;
    int         cnt;
  } vec_t;

  vec_t tbl[11];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int rel[N];
    bit p;
    bit s;

    tbl[0]  = '{1'b1, 1'b0, 25, 3'b000, 2'd1, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0,  1, 3'b001, 2'd2, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 15, 3'b001, 2'd2, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0,  1, 3'b011, 2'd2, 1'b0, 0};
    tbl[4]  = '{1'b1, 1'b0, 16, 3'b111, 2'd3, 1'b1, 0};
    tbl[5]  = '{1'b1, 1'b1,  1, 3'b000, 2'd1, 1'b0, 0};
    tbl[6]  = '{1'b1, 1'b0, 16, 3'b001, 2'd2, 1'b0, 0};
    tbl[7]  = '{1'b0, 1'b0,  1, 3'b001, 2'd2, 1'b0, 0};
    tbl[8]  = '{1'b1, 1'b0,  1, 3'b001, 2'd2, 1'b0, 0};
    tbl[9]  = '{1'b1, 1'b0,  1, 3'b000, 2'd0, 1'b0, 1};
    tbl[10] = '{1'b1, 1'b0,  8, 3'b000, 2'd1, 1'b0, 1};

    // Table: nominal bring-up, soft reset, short lock drop.
    do_reset();
    for (int r = 0; r < 11; r++) begin
      for (int c = 0; c < tbl[r].cycles; c++) step(tbl[r].pll, tbl[r].sw, "tbl_model");
      chk($sformatf("tbl%0d_stage", r), int'(bus.stage_resetn), int'(tbl[r].stage));
      chk($sformatf("tbl%0d_state", r), int'(bus.seq_state), int'(tbl[r].state));
      chk($sformatf("tbl%0d_all", r), int'(bus.all_released), int'(tbl[r].all));
      chk($sformatf("tbl%0d_cnt", r), int'(bus.lock_loss_cnt), tbl[r].cnt);
    end

    // Lock glitching in HOLD never qualifies.
    do_reset();
    for (int i = 0; i < 60; i++) step((i % 5) != 4, 1'b0, "hold_glitch");
    chk("hold_glitch_state", int'(bus.seq_state), 0);
    chk("hold_glitch_stage", int'(bus.stage_resetn), 0);
    chk("hold_glitch_cnt", int'(bus.lock_loss_cnt), 0);

    // Lock loss in RUN, then full re-release latency.
    do_reset();
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0, "to_run");
    chk("run_state", int'(bus.seq_state), 3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "loss");
    chk("loss_stage", int'(bus.stage_resetn), 0);
    chk("loss_cnt", int'(bus.lock_loss_cnt), 1);
    step(1'b0, 1'b0, "loss");
    for (int j = 0; j < N; j++) rel[j] = -1;
    for (int k = 1; k <= 70; k++) begin
      step(1'b1, 1'b0, "relock");
      for (int j = 0; j < N; j++)
        if (rel[j] < 0 && bus.stage_resetn[j]) rel[j] = k;
    end
    for (int j = 0; j < N; j++)
      chk($sformatf("relock_stage%0d_edge", j), rel[j], SYNC + LF + HC + j * GAP);

    // Soft reset pulse in RUN.
    step(1'b1, 1'b1, "sw_pulse");
    chk("sw_stage", int'(bus.stage_resetn), 0);
    chk("sw_cnt", int'(bus.lock_loss_cnt), 1);
    for (int j = 0; j < N; j++) rel[j] = -1;
    for (int k = 1; k <= 60; k++) begin
      step(1'b1, 1'b0, "sw_rerelease");
      for (int j = 0; j < N; j++)
        if (rel[j] < 0 && bus.stage_resetn[j]) rel[j] = k;
    end
    for (int j = 0; j < N; j++)
      chk($sformatf("sw_stage%0d_edge", j), rel[j], HC + j * GAP);

    // Soft reset coinciding with lock loss, then saturate the loss counter.
    step(1'b0, 1'b0, "sw_and_loss");
    step(1'b0, 1'b0, "sw_and_loss");
    step(1'b0, 1'b1, "sw_and_loss");
    chk("sw_loss_state", int'(bus.seq_state), 0);
    chk("sw_loss_cnt", int'(bus.lock_loss_cnt), 2);
    step(1'b0, 1'b0, "sw_and_loss");
    step(1'b0, 1'b0, "sw_and_loss");
    for (int e = 0; e < 300; e++) begin
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, "sat");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "sat");
    end
    chk("sat_cnt", int'(bus.lock_loss_cnt), 255);
    chk("sat_state", int'(bus.seq_state), 0);

    // ext_reset mid-RELEASE clears outputs without a clock edge.
    for (int k = 0; k < 100 && bus.stage_resetn != 3'b001; k++) step(1'b1, 1'b0, "to_release");
    chk("pre_ext_stage", int'(bus.stage_resetn), 1);
    #2 ext_reset = 1'b0;
    #1;
    chk("ext_async_stage", int'(bus.stage_resetn), 0);
    chk("ext_async_all", int'(bus.all_released), 0);
    chk("ext_async_state", int'(bus.seq_state), 0);
    chk("ext_async_cnt", int'(bus.lock_loss_cnt), 0);
    @(negedge clk);
    model_reset();
    ext_reset = 1'b1;
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, "post_ext");

    // Random bursty lock and occasional soft reset.
    do_reset();
    p = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (p) p = ($urandom_range(0, 99) >= 1);
      else   p = ($urandom_range(0, 99) < 30);
      s = ($urandom_range(0, 99) < 1);
      step(p, s, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
